// File: rtl/uart_tx_frame_sender.sv
// uart_tx_frame_sender
//   Buffers 2-byte response frames {frame_code, frame_value} in a small FIFO and
//   feeds them one byte at a time to a UART transmitter. Each byte is offered with
//   a single-cycle has_data strobe. The next byte is not offered until the
//   transmitter has gone busy, signalled done, and returned to idle.
//
//   Optional build macro: UART_TX_CHECKSUM_EN. When it is defined, a third byte
//   (frame_code ^ frame_value) is appended to every frame.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   frame_valid/ready   upstream frame handshake (see note below)
//   frame_code/value    frame bytes; code is sent first
//   tx_busy, tx_done    transmitter is_transmitting / transmission_done
//   has_data            one-cycle start strobe to the transmitter
//   data_to_send        byte for the transmitter; held until the transmitter is idle again
//   fifo_count          frames currently stored (0..DEPTH)
//   overflow            sticky; set when a frame is offered while the FIFO is full
//   sender_busy         FIFO non-empty or a frame is in flight
//   state_dbg           current FSM state encoding, for observation
//
// Handshake: a frame is accepted on a rising edge where frame_valid && frame_ready.
// frame_ready depends only on fifo_count. It does not depend on frame_valid.
// A frame offered while frame_ready is low is dropped, and overflow is raised.
module uart_tx_frame_sender #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [7:0]        frame_code,
  input  logic [7:0]        frame_value,
  output logic              frame_ready,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              has_data,
  output logic [7:0]        data_to_send,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              sender_busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_STROBE     = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4,
    S_WAIT_IDLE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

`ifdef UART_TX_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [15:0]       frame_reg;
  logic [1:0]        byte_idx;
  logic [7:0]        cur_byte;
  state_t            state;
  logic              push;
  logic              pop;

  assign frame_ready = (fifo_count != FULL_COUNT);
  assign push        = frame_valid & frame_ready;
  assign sender_busy = (state != S_IDLE) | (fifo_count != '0);
  assign state_dbg   = state;

  // A frame is popped from the FIFO in two cases:
  //   - from IDLE, when the FIFO is not empty;
  //   - when the last byte of the current frame has fully finished and another
  //     frame is waiting. This chains frames without passing through IDLE.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:      pop = (fifo_count != '0);
      S_WAIT_IDLE: pop = !tx_done && !tx_busy && (byte_idx == LAST_IDX) &&
                         (fifo_count != '0);
      default:     pop = 1'b0;
    endcase
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = frame_reg[15:8];
`ifdef UART_TX_CHECKSUM_EN
      2'd2:    cur_byte = frame_reg[15:8] ^ frame_reg[7:0];
`endif
      default: cur_byte = frame_reg[7:0];
    endcase
  end

  // Frame storage. It has no reset; only the pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {frame_code, frame_value};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // The pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (frame_valid && !frame_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      frame_reg    <= '0;
      byte_idx     <= '0;
      has_data     <= 1'b0;
      data_to_send <= 8'h00;
    end else begin
      has_data <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            frame_reg <= mem[rd_ptr];
            byte_idx  <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          // has_data is registered, so it is high exactly during STROBE.
          data_to_send <= cur_byte;
          has_data     <= 1'b1;
          state        <= S_STROBE;
        end
        S_STROBE: state <= S_WAIT_START;
        S_WAIT_START: begin
          if (tx_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_done) state <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          // tx_done stays high for two cycles. Waiting for it to clear means
          // each strobe produces exactly one byte.
          if (!tx_done && !tx_busy) begin
            if (byte_idx != LAST_IDX) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= S_LOAD;
            end else if (pop) begin
              frame_reg <= mem[rd_ptr];
              byte_idx  <= '0;
              state     <= S_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_sender.sv
// Directed bench for uart_tx_frame_sender.
// A small behavioural transmitter answers each strobe. It goes busy for 8 cycles,
// then drives done for 2 cycles, and records each byte that completes.
module tb_uart_tx_frame_sender;

`ifdef UART_TX_CHECKSUM_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_valid = 1'b0;
  logic [7:0] frame_code = 8'h00;
  logic [7:0] frame_value = 8'h00;
  logic       frame_ready;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       has_data;
  logic [7:0] data_to_send;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       sender_busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  logic stub = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic [7:0] codes [5] = '{8'h10, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] vals  [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [2:0] cnts  [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

  int         m_st = 0;
  int         m_cnt = 0;
  logic [7:0] m_cap = 8'h00;

  uart_tx_frame_sender #(.DEPTH(4), .ADDR_W(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_valid  (frame_valid),
    .frame_code   (frame_code),
    .frame_value  (frame_value),
    .frame_ready  (frame_ready),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .has_data     (has_data),
    .data_to_send (data_to_send),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .sender_busy  (sender_busy),
    .state_dbg    (state_dbg)
  );

  // clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // transmitter model, updated away from the DUT's active edge
  always @(negedge clock) begin
    if (reset) begin
      m_st = 0;
      tx_busy = 1'b0;
      tx_done = 1'b0;
    end else begin
      if (has_data) pulses++;
      case (m_st)
        0: if (has_data && !stub) begin
             m_cap = data_to_send;
             tx_busy = 1'b1;
             m_cnt = 8;
             m_st = 1;
           end
        1: begin
             check("data_stable", data_to_send, m_cap);
             m_cnt--;
             if (m_cnt == 0) begin
               tx_busy = 1'b0;
               tx_done = 1'b1;
               m_cnt = 2;
               m_st = 2;
               got_q.push_back(m_cap);
             end
           end
        2: begin
             m_cnt--;
             if (m_cnt == 0) begin
               tx_done = 1'b0;
               m_st = 0;
             end
           end
        default: m_st = 0;
      endcase
    end
  end

  task automatic push_exp(input logic [7:0] c, input logic [7:0] v);
    exp_q.push_back(c);
    exp_q.push_back(v);
`ifdef UART_TX_CHECKSUM_EN
    exp_q.push_back(c ^ v);
`endif
  endtask

  task automatic compare_sb(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sender_busy !== 1'b0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_drain"}, sender_busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, frame_ready, 1);
    check({tag, "_has_data"}, has_data, 0);
    check({tag, "_data"}, data_to_send, 8'h00);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_busy"}, sender_busy, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("rst");
    @(negedge clock);
    reset = 1'b0;

    // single frame: latency, byte order, pulse count
    p0 = pulses;
    @(negedge clock);
    frame_valid = 1'b1; frame_code = 8'hA1; frame_value = 8'h3C;
    push_exp(8'hA1, 8'h3C);
    @(posedge clock); #1;
    frame_valid = 1'b0;
    check("t1_count_push", fifo_count, 1);
    check("t1_busy", sender_busy, 1);
    check("t1_idle_cycle", state_dbg, 0);
    check("t1_no_strobe0", has_data, 0);
    @(posedge clock); #1;
    check("t1_load", state_dbg, 1);
    check("t1_count_pop", fifo_count, 0);
    check("t1_no_strobe1", has_data, 0);
    @(posedge clock); #1;
    check("t1_strobe", has_data, 1);
    check("t1_first_byte", data_to_send, 8'hA1);
    @(posedge clock); #1;
    check("t1_strobe_end", has_data, 0);
    check("t1_wait_start", state_dbg, 3);
    wait_drain("t1", 300);
    check("t1_pulses", pulses - p0, NBYTES);
    compare_sb("t1");

    // five frames back-to-back, then one more offered while full
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      frame_valid = 1'b1; frame_code = codes[i]; frame_value = vals[i];
      push_exp(codes[i], vals[i]);
      @(posedge clock); #1;
      check("t2_count", fifo_count, cnts[i]);
    end
    check("t2_full_ready", frame_ready, 0);
    check("t2_no_overflow_yet", overflow, 0);
    @(negedge clock);
    frame_code = 8'h66; frame_value = 8'h06;
    @(posedge clock); #1;
    frame_valid = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_count_full", fifo_count, 4);
    wait_drain("t2", 2000);
    check("t2_pulses", pulses - p0, 5 * NBYTES);
    check("t2_overflow_sticky", overflow, 1);
    compare_sb("t2");

    // stubbed transmitter: FSM must hold in WAIT_START
    stub = 1'b1;
    p0 = pulses;
    @(negedge clock);
    frame_valid = 1'b1; frame_code = 8'h77; frame_value = 8'h88;
    @(posedge clock); #1;
    frame_valid = 1'b0;
    for (int n = 0; n < 20 && pulses == p0; n++) begin
      @(posedge clock); #1;
    end
    repeat (10) @(posedge clock);
    #1;
    check("t3_pulses", pulses - p0, 1);
    check("t3_state", state_dbg, 3);
    check("t3_has_data", has_data, 0);
    check("t3_data", data_to_send, 8'h77);
    check("t3_busy", sender_busy, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("t3_rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    stub = 1'b0;
    compare_sb("t3");

    // reset during the second byte, then a clean frame
    p0 = pulses;
    @(negedge clock);
    frame_valid = 1'b1; frame_code = 8'hB2; frame_value = 8'hC3;
    exp_q.push_back(8'hB2);
    @(posedge clock); #1;
    frame_valid = 1'b0;
    for (int n = 0; n < 300 && pulses != p0 + 2; n++) begin
      @(negedge clock); #1;
    end
    check("t4_second_strobe", pulses - p0, 2);
    check("t4_second_byte", data_to_send, 8'hC3);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("t4_rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_sb("t4");

    p0 = pulses;
    @(negedge clock);
    frame_valid = 1'b1; frame_code = 8'hD4; frame_value = 8'hE5;
    push_exp(8'hD4, 8'hE5);
    @(posedge clock); #1;
    frame_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("t5_strobe", has_data, 1);
    check("t5_first_byte", data_to_send, 8'hD4);
    wait_drain("t5", 300);
    check("t5_pulses", pulses - p0, NBYTES);
    compare_sb("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
